// File: rtl/can_bit_timing.sv
// ---------------------------------------------------------------------------
// can_bit_timing
//
// Bit timing unit of the CAN controller. Each nominal bit is divided into
// time quanta (one quantum per tq_en tick):
//   SYNC (1 quantum) -> TSEG1 (lim1 quanta) -> TSEG2 (lim2 quanta).
// The bus is sampled at the end of TSEG1 and a new bit starts (send point)
// at the end of TSEG2. Falling (recessive-to-dominant) edges on rx drive hard
// synchronisation (restart the bit) or resynchronisation (stretch TSEG1 or
// shorten TSEG2 by at most the jump width).
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   tq_en        time-quantum tick, one clk wide; all timing advances on it
//   rx           bus level synchronised to clk (1 = recessive)
//   sjw          jump width code, width = code+1 quanta
//   tseg1        TSEG1 code, length = code+1 quanta
//   tseg2        TSEG2 code, length = code+1 quanta
//   hardsync_en  an edge inside this window causes hard synchronisation
//   resync_en    resynchronisation permitted
//   sample       one-clk pulse after the tick that ends TSEG1
//   rxbit        bus value captured at the sample point
//   sendpoint    one-clk pulse after the tick that starts a new bit
//   seg          current segment: 00 SYNC, 01 TSEG1, 10 TSEG2 (FSM state)
// ---------------------------------------------------------------------------
module can_bit_timing #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tq_en,
    input  logic       rx,
    input  logic [2:0] sjw,
    input  logic [2:0] tseg1,
    input  logic [2:0] tseg2,
    input  logic       hardsync_en,
    input  logic       resync_en,
    output logic       sample,
    output logic       rxbit,
    output logic       sendpoint,
    output logic [1:0] seg
);

    // Limits need one bit more than the counter: an extended TSEG1 can be 16.
    localparam int LW = CNT_W + 1;

    typedef enum logic [1:0] {
        SEG_SYNC  = 2'b00,
        SEG_TSEG1 = 2'b01,
        SEG_TSEG2 = 2'b10
    } seg_t;

    seg_t             seg_q, seg_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [LW-1:0]    lim1_q, lim1_n;
    logic [LW-1:0]    lim2_q, lim2_n;
    logic [LW-1:0]    sjwe_q, sjwe_n;
    logic             flag_q, flag_n;   // a resync/hard sync already happened this bit
    logic             rx_last_q;
    logic             sample_d, send_d;
    logic             enter_t1;

    logic             edge_det, do_hard, do_resync, neg_jump;
    logic [LW-1:0]    cnt_x, ext, rem, lim1_adj, lim2_adj;
    logic [LW-1:0]    cfg_lim1, cfg_lim2, cfg_sjwe;

    // Values loaded whenever a bit enters TSEG1 afresh (and at reset).
    assign cfg_lim1 = LW'(tseg1) + LW'(1);
    assign cfg_lim2 = LW'(tseg2) + LW'(1);
    assign cfg_sjwe = LW'((sjw < tseg2) ? sjw : tseg2) + LW'(1);

    assign edge_det  = rx_last_q & ~rx;
    assign do_hard   = hardsync_en & edge_det;
    assign do_resync = resync_en & ~hardsync_en & edge_det & ~flag_q;

    assign cnt_x = LW'(cnt_q);

    // Positive phase error: the edge arrived late in TSEG1; stretch TSEG1 by
    // the elapsed TSEG1 quanta, clamped to the jump width.
    assign ext      = cnt_x + LW'(1);
    assign lim1_adj = do_resync ? (lim1_q + ((ext < sjwe_q) ? ext : sjwe_q)) : lim1_q;

    // Negative phase error: quanta left in TSEG2 after the edge quantum. If it
    // fits in the jump width the edge quantum becomes the next SYNC.
    assign rem      = lim2_q - cnt_x - LW'(1);
    assign neg_jump = do_resync & (rem <= sjwe_q);
    assign lim2_adj = do_resync ? (lim2_q - sjwe_q) : lim2_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q     <= SEG_SYNC;
            cnt_q     <= '0;
            lim1_q    <= cfg_lim1;
            lim2_q    <= cfg_lim2;
            sjwe_q    <= cfg_sjwe;
            flag_q    <= 1'b0;
            rx_last_q <= 1'b1;
            sample    <= 1'b0;
            sendpoint <= 1'b0;
            rxbit     <= 1'b1;
        end else begin
            sample    <= sample_d;
            sendpoint <= send_d;
            if (tq_en) begin
                seg_q     <= seg_n;
                cnt_q     <= cnt_n;
                lim1_q    <= lim1_n;
                lim2_q    <= lim2_n;
                sjwe_q    <= sjwe_n;
                flag_q    <= flag_n;
                rx_last_q <= rx;
            end
            if (sample_d) begin
                rxbit <= rx;
            end
        end
    end

    // Next-state logic, evaluated for a tick
    always_comb begin
        seg_n    = seg_q;
        cnt_n    = cnt_q;
        lim1_n   = lim1_q;
        lim2_n   = lim2_q;
        sjwe_n   = sjwe_q;
        flag_n   = flag_q;
        enter_t1 = 1'b0;
        if (do_hard) begin
            seg_n    = SEG_TSEG1;
            cnt_n    = '0;
            flag_n   = 1'b1;
            enter_t1 = 1'b1;
        end else begin
            if (do_resync) begin
                flag_n = 1'b1;
            end
            case (seg_q)
                SEG_SYNC: begin
                    // An edge here has zero phase error; only the flag moves.
                    seg_n    = SEG_TSEG1;
                    cnt_n    = '0;
                    enter_t1 = 1'b1;
                end
                SEG_TSEG1: begin
                    lim1_n = lim1_adj;
                    if (cnt_x == lim1_adj - LW'(1)) begin
                        seg_n = SEG_TSEG2;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                SEG_TSEG2: begin
                    if (neg_jump) begin
                        // Flag stays set: the new bit already used its resync.
                        seg_n    = SEG_TSEG1;
                        cnt_n    = '0;
                        enter_t1 = 1'b1;
                    end else begin
                        lim2_n = lim2_adj;
                        if (cnt_x == lim2_adj - LW'(1)) begin
                            seg_n  = SEG_SYNC;
                            cnt_n  = '0;
                            flag_n = 1'b0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    seg_n = SEG_SYNC;
                    cnt_n = '0;
                end
            endcase
        end
        if (enter_t1) begin
            lim1_n = cfg_lim1;
            lim2_n = cfg_lim2;
            sjwe_n = cfg_sjwe;
        end
    end

    // Output decode: pulses come from the segment transition taken this tick.
    always_comb begin
        sample_d = 1'b0;
        send_d   = 1'b0;
        if (tq_en) begin
            sample_d = (seg_q == SEG_TSEG1) && (seg_n == SEG_TSEG2);
            send_d   = do_hard || ((seg_q == SEG_TSEG2) && (seg_n != SEG_TSEG2));
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_can_bit_timing.sv
module tb_can_bit_timing;

  logic       clk = 1'b0;
  logic       rst, tq_en, rx, hardsync_en, resync_en;
  logic [2:0] sjw, tseg1, tseg2;
  logic       sample, rxbit, sendpoint;
  logic [1:0] seg;
  logic [4:0] dut_vec;

  int n_cmp = 0;
  int n_err = 0;
  int ticks = 0;

  // Reference model: position m_p of the quantum in progress within the bit
  // (0 = SYNC, 1..L1 = TSEG1, L1+1..L1+L2 = TSEG2).
  int m_p, m_l1, m_l2, m_sjwe;
  bit m_flag, m_rxlast, m_rxbit, m_smp, m_snd;

  int exp_q[$];

  always #5 clk = ~clk;

  can_bit_timing #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .tq_en(tq_en), .rx(rx),
    .sjw(sjw), .tseg1(tseg1), .tseg2(tseg2),
    .hardsync_en(hardsync_en), .resync_en(resync_en),
    .sample(sample), .rxbit(rxbit), .sendpoint(sendpoint), .seg(seg)
  );

  assign dut_vec = {seg, sample, sendpoint, rxbit};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_latch();
    m_l1   = int'(tseg1) + 1;
    m_l2   = int'(tseg2) + 1;
    m_sjwe = ((sjw < tseg2) ? int'(sjw) : int'(tseg2)) + 1;
  endtask

  task automatic model_reset();
    m_p = 0; m_flag = 0; m_rxlast = 1; m_rxbit = 1; m_smp = 0; m_snd = 0;
    model_latch();
  endtask

  task automatic model_tick();
    bit edge_v, rsy;
    edge_v = m_rxlast && !rx;
    m_rxlast = rx;
    m_smp = 0; m_snd = 0;
    if (hardsync_en && edge_v) begin
      m_p = 1; model_latch(); m_snd = 1; m_flag = 1;
    end else begin
      rsy = resync_en && edge_v && !m_flag;
      if (rsy) m_flag = 1;
      if (m_p == 0) begin
        m_p = 1; model_latch();
      end else if (m_p <= m_l1) begin
        if (rsy) m_l1 += (m_p < m_sjwe) ? m_p : m_sjwe;
        if (m_p == m_l1) begin m_smp = 1; m_rxbit = rx; end
        m_p++;
      end else if (rsy && (m_l1 + m_l2 - m_p) <= m_sjwe) begin
        m_p = 1; model_latch(); m_snd = 1;
      end else begin
        if (rsy) m_l2 -= m_sjwe;
        if (m_p == m_l1 + m_l2) begin m_snd = 1; m_p = 0; m_flag = 0; end
        else m_p++;
      end
    end
  endtask

  function automatic logic [4:0] m_vec();
    logic [1:0] s;
    if (m_p == 0) s = 2'b00;
    else if (m_p <= m_l1) s = 2'b01;
    else s = 2'b10;
    return {s, m_smp, m_snd, m_rxbit};
  endfunction

  // Drive one clk cycle and advance the model alongside.
  task automatic drive(input bit t, input bit r, input bit rs_i);
    @(negedge clk);
    rst = rs_i; tq_en = t; rx = r;
    if (rs_i) begin model_reset(); ticks = 0; end
    else if (t) begin model_tick(); ticks++; end
    else begin m_smp = 0; m_snd = 0; end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int s, input int t1, input int t2, input bit hs, input bit rs);
    sjw = 3'(s); tseg1 = 3'(t1); tseg2 = 3'(t2); hardsync_en = hs; resync_en = rs;
  endtask

  task automatic test_reset();
    set_cfg(0, 3, 2, 0, 0);
    drive(0, 1, 1);
    n_cmp++;
    if (dut_vec !== 5'b00_0_0_1) begin
      n_err++; $display("FAIL reset_state got %b expected %b", dut_vec, 5'b00001);
    end
    drive(0, 1, 0);
  endtask

  task automatic test_nominal();
    int sq[$];
    int e;
    set_cfg(0, 3, 2, 0, 0);
    drive(0, 1, 1);
    sq = '{5, 13, 21};
    exp_q = '{8, 16, 24};
    for (int i = 0; i < 24; i++) begin
      drive(1, 1, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL nominal_tick tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
      if (sample) begin
        e = (sq.size() > 0) ? sq.pop_front() : -1;
        n_cmp++;
        if (ticks != e) begin n_err++; $display("FAIL nominal_sample_at got tick %0d expected %0d", ticks, e); end
      end
      if (sendpoint) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (ticks != e) begin n_err++; $display("FAIL nominal_send_at got tick %0d expected %0d", ticks, e); end
      end
      drive(0, 1, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL nominal_idle tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
    end
    n_cmp++;
    if (sq.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL nominal_missing_pulses got %0d/%0d left expected 0/0", sq.size(), exp_q.size());
    end
  endtask

  task automatic test_pos_resync();
    int sq[$];
    int e, nb;
    bit r;
    set_cfg(1, 3, 2, 0, 1);
    drive(0, 1, 1);
    sq = '{6, 16, 24};
    exp_q = '{9, 19, 27};
    nb = 0;
    for (int i = 0; i < 27; i++) begin
      r = 1;
      if (nb == 0 && (m_p == 1 || m_p == 3)) r = 0;
      if (nb == 1 && m_p == 3) r = 0;
      drive(1, r, 0);
      if (m_snd) nb++;
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL pos_resync_tick tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
      if (sample) begin
        e = (sq.size() > 0) ? sq.pop_front() : -1;
        n_cmp++;
        if (ticks != e) begin n_err++; $display("FAIL pos_resync_sample_at got tick %0d expected %0d", ticks, e); end
      end
      if (sendpoint) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        n_cmp++;
        if (ticks != e) begin n_err++; $display("FAIL pos_resync_send_at got tick %0d expected %0d", ticks, e); end
      end
    end
    n_cmp++;
    if (sq.size() != 0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL pos_resync_missing_pulses got %0d/%0d left expected 0/0", sq.size(), exp_q.size());
    end
  endtask

  task automatic test_neg_resync(input int sjw_v, input int exp_len);
    int first, nb;
    bit r;
    set_cfg(sjw_v, 3, 2, 0, 1);
    drive(0, 1, 1);
    first = -1; nb = 0;
    for (int i = 0; i < 20; i++) begin
      r = (nb == 0 && m_p == 5) ? 0 : 1;
      drive(1, r, 0);
      if (m_snd) nb++;
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL neg_resync_tick sjw=%0d tick=%0d got %b expected %b", sjw_v, ticks, dut_vec, m_vec());
      end
      if (sendpoint && first < 0) first = ticks;
    end
    n_cmp++;
    if (first != exp_len) begin
      n_err++; $display("FAIL neg_resync_bit_len sjw=%0d got %0d expected %0d", sjw_v, first, exp_len);
    end
  endtask

  task automatic test_hard_sync();
    bit hit, got;
    int k;
    set_cfg(1, 3, 2, 1, 1);
    drive(0, 1, 1);
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      if (m_p == 6) begin drive(1, 0, 0); hit = 1; end
      else drive(1, 1, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL hard_sync_tick tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
    end
    n_cmp++;
    if (!hit || {seg, sample, sendpoint} !== 4'b01_0_1) begin
      n_err++; $display("FAIL hard_sync_jump got %b expected %b", {seg, sample, sendpoint}, 4'b0101);
    end
    k = 0; got = 0;
    for (int j = 0; j < 10 && !got; j++) begin
      drive(1, 0, 0);
      k++;
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL hard_sync_after tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
      if (sample) got = 1;
    end
    n_cmp++;
    if (!got || k != 4 || rxbit !== 1'b0) begin
      n_err++; $display("FAIL hard_sync_sample got k=%0d rxbit=%b expected k=4 rxbit=0", k, rxbit);
    end
  endtask

  task automatic test_sjw_clamp();
    int s_at, p_at;
    bit r;
    set_cfg(7, 7, 1, 0, 1);
    drive(0, 1, 1);
    s_at = -1; p_at = -1;
    for (int i = 0; i < 16; i++) begin
      r = (ticks < 8 && m_p == 6) ? 0 : 1;
      drive(1, r, 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL sjw_clamp_tick tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
      end
      if (sample && s_at < 0) s_at = ticks;
      if (sendpoint && p_at < 0) p_at = ticks;
    end
    n_cmp++;
    if (s_at != 11 || p_at != 13) begin
      n_err++; $display("FAIL sjw_clamp_len got sample@%0d send@%0d expected sample@11 send@13", s_at, p_at);
    end
  endtask

  task automatic test_cfg_change();
    int e, nb;
    bit done;
    set_cfg(0, 3, 2, 0, 0);
    drive(0, 1, 1);
    exp_q = '{8, 18};
    nb = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (nb == 0 && m_p > m_l1) tseg1 = 3'd5;
      if (nb == 2 && m_p == 2) begin
        drive(1, 0, 1);
        done = 1;
        n_cmp++;
        if (dut_vec !== 5'b00_0_0_1) begin
          n_err++; $display("FAIL cfg_midbit_reset got %b expected %b", dut_vec, 5'b00001);
        end
      end else begin
        drive(1, (nb >= 1) ? 1'b0 : 1'b1, 0);
        if (m_snd) nb++;
        n_cmp++;
        if (dut_vec !== m_vec()) begin
          n_err++; $display("FAIL cfg_change_tick tick=%0d got %b expected %b", ticks, dut_vec, m_vec());
        end
        if (sendpoint) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          n_cmp++;
          if (ticks != e) begin n_err++; $display("FAIL cfg_change_send_at got tick %0d expected %0d", ticks, e); end
        end
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL cfg_change_timeout got done=0 expected done=1");
    end
  endtask

  task automatic test_random();
    bit r;
    set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 1);
    drive(0, 1, 1);
    r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        sjw = 3'($urandom_range(0, 7)); tseg1 = 3'($urandom_range(0, 7)); tseg2 = 3'($urandom_range(0, 7));
      end
      hardsync_en = ($urandom_range(0, 7) == 0);
      resync_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) r = ~r;
      drive($urandom_range(0, 1) == 1, r, $urandom_range(0, 199) == 0);
      n_cmp++;
      if (dut_vec !== m_vec()) begin
        n_err++; $display("FAIL random_cycle i=%0d got %b expected %b", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    rst = 1; tq_en = 0; rx = 1;
    set_cfg(0, 3, 2, 0, 0);
    test_reset();
    test_nominal();
    test_pos_resync();
    test_neg_resync(1, 6);
    test_neg_resync(0, 7);
    test_hard_sync();
    test_sjw_clamp();
    test_cfg_change();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Bit timing unit of the CAN controller.
- Reads the timing fields programmed into the general register (sjw, tseg1, tseg2) and segments every nominal bit into SYNC / TSEG1 / TSEG2 time quanta.
- Produces the sample-point pulse and received bit for the receive path, and the send-point pulse for the transmit path.
- Performs hard synchronisation and resynchronisation on recessive-to-dominant edges of the bus input.

Parameters:
CNT_W, 4, quantum counter width; must hold 0..15 (maximum extended TSEG1 = 8+8 quanta).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tq_en  input  1  time-quantum tick from the prescaler; one clk wide; all timing acts only on clk cycles with tq_en=1
rx  input  1  bus level, already synchronised to clk (1 = recessive)
sjw  input  3  synchronisation jump width code; width = code+1 quanta
tseg1  input  3  TSEG1 code; length = code+1 quanta
tseg2  input  3  TSEG2 code; length = code+1 quanta
hardsync_en  input  1  bus idle / start-of-frame window; an edge triggers hard sync
resync_en  input  1  resynchronisation permitted
sample  output  1  one-clk pulse at the sample point
rxbit  output  1  bus value captured at the sample point
sendpoint  output  1  one-clk pulse at the start of each bit
seg  output  2  current segment: 00 SYNC, 01 TSEG1, 10 TSEG2

Behaviour:
- Reset (rst=1 at a clk edge), including mid-bit:
  - seg=SYNC, cnt=0, sample=0, sendpoint=0, rxbit=1, rx_last=1, resync flag cleared.
  - Latched limits: lim1=tseg1+1, lim2=tseg2+1.
- No state change on cycles with tq_en=0.
- sample and sendpoint are registered. Each is high for exactly the one clk cycle after the qualifying tick, else 0.
- Edge detection:
  - edge=1 on a tick where rx_last=1 and rx=0.
  - rx_last is updated on every tick only.
  - Rising edges are ignored.
- Effective jump width: sjwe = min(sjw, tseg2)+1.
- Config latch: lim1, lim2 and sjwe are reloaded from the inputs on every transition into TSEG1 with cnt=0. Changes mid-bit take effect at the next bit.
- Normal tick sequence, no edge:
  - SYNC: go to TSEG1, cnt=0.
  - TSEG1, cnt<lim1-1: cnt++.
  - TSEG1, cnt=lim1-1: go to TSEG2, cnt=0, pulse sample, rxbit<=rx.
  - TSEG2, cnt<lim2-1: cnt++.
  - TSEG2, cnt=lim2-1: go to SYNC, pulse sendpoint, clear resync flag.
- Edge handling; priority is hard sync > resync > normal. The edge is attributed to the quantum ending at the tick.
  - Hard sync (hardsync_en=1, edge, any segment): go to TSEG1, cnt=0, pulse sendpoint, set resync flag. No sample pulse on this tick.
  - Resync applies only when resync_en=1, hardsync_en=0, edge, and the resync flag is clear; it then sets the flag. Max one resync per bit.
  - Resync in SYNC: phase error 0, no action except setting the flag.
  - Resync in TSEG1: e=cnt+1. Set lim1 += min(e, sjwe), then apply the normal TSEG1 rule with the new lim1. Consequently there is no sample on a tick that would otherwise end TSEG1.
  - Resync in TSEG2: rem = lim2-cnt-1.
    - If rem <= sjwe: go to TSEG1, cnt=0, pulse sendpoint. The edge quantum serves as SYNC; the flag stays set for the new bit.
    - Else: lim2 -= sjwe, then apply the normal TSEG2 rule.
- Nominal bit length = 1 + lim1 + lim2 ticks, range 3..17.
- Simultaneous tq_en and rst: reset wins.

Test Plan:
- tseg1=3, tseg2=2, sjw=0, rx held 1, 24 ticks:
  - sample pulses after ticks 5, 13, 21; sendpoint after ticks 8, 16, 24.
  - seg sequence per bit: 00, 01×4, 10×3.
- Positive resync, tseg1=3, tseg2=2, sjw=1, resync_en=1:
  - Edge on the tick with TSEG1 cnt=0: sample moves one tick later; bit = 9 ticks.
  - Edge at TSEG1 cnt=2: extension 2; bit = 10 ticks.
  - A second edge in the same bit: no further change.
- Negative resync, same config:
  - Edge at TSEG2 cnt=0: rem=2 <= sjwe=2, so sendpoint pulses on that tick; bit = 6 ticks.
  - Repeated with sjw=0: lim2 becomes 2; bit = 7 ticks.
- Hard sync, hardsync_en=1, edge at TSEG2 cnt=1:
  - Immediate seg=01, cnt=0, sendpoint pulse, no sample.
  - Next sample after 4 ticks, rxbit=0.
- sjw=7 with tseg2=1: sjwe=2. Edge at TSEG1 cnt=5 with tseg1=7: lim1 becomes 10.
- Config change mid-bit: tseg1 changed from 3 to 5 during TSEG2; takes effect at the next TSEG1 entry. rst asserted during TSEG1: next cycle seg=00, rxbit=1, no pulses.
